align_shift_right: RTL and testbench

- Multi-cycle right shifter with sticky-bit capture, used by the FP divider for exponent alignment and denormal shifting.
- Counterpart to the combinational left-shift barrel used for normalization.
- Applies one log2 stage per clock: 2^0, 2^1, … 2^(AMT_W-1).
- Accumulates the OR of all shifted-out bits as a sticky bit for rounding.
- Valid/ready handshake on both input and output.

---
 rtl/shift_pkg.sv | 26 ++
 rtl/align_shift_right_sr_stage.sv | 40 ++++
 rtl/align_shift_right.sv | 101 ++++++++++
 tb/tb_align_shift_right.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// ============================================================================
// Module : shift_pkg
// Brief  : Shared types, defaults and mask helper for align_shift_right.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int AMT_W_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Low 2^k bits set; k == log2(WIDTH_DEF) yields all ones.
  function automatic logic [WIDTH_DEF-1:0] stage_mask(input int unsigned k);
    return ~({WIDTH_DEF{1'b1}} << (32'd1 << k));
  endfunction

endpackage

`default_nettype wire

// File: rtl/align_shift_right_sr_stage.sv
// ============================================================================
// Module : sr_stage
// Brief  : One log2 right-shift stage (shift by 2^k) with lost-bit OR.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AMT_W = AMT_W_DEF,
  parameter int K_W   = (AMT_W > 1) ? $clog2(AMT_W) : 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic [K_W-1:0]   k,
  input  logic             en,
  input  logic             arith,
  input  logic             sign,
  output logic [WIDTH-1:0] shifted,
  output logic             lost_bits_or
);

  logic [AMT_W:0]   w_dist;
  logic [WIDTH-1:0] w_keep;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_fill;

  assign w_dist = (AMT_W+1)'(1) << k;
  assign w_keep = {WIDTH{1'b1}} >> w_dist;
  assign w_mask = WIDTH'(stage_mask(32'(k)));
  assign w_fill = {WIDTH{arith & sign}};

  // Vacated top bits take the fill pattern; sticky sees only real data bits.
  assign shifted      = en ? ((data >> w_dist) | (~w_keep & w_fill)) : data;
  assign lost_bits_or = en & (|(data & w_mask));

endmodule

`default_nettype wire

// File: rtl/align_shift_right.sv
// ============================================================================
// Module : align_shift_right
// Brief  : Multi-cycle right shifter, one log2 stage per clock, with sticky.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module align_shift_right
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AMT_W = AMT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sticky
);

  localparam int CNT_W = (AMT_W > 1) ? $clog2(AMT_W) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(AMT_W - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_data;
  logic [AMT_W-1:0] r_amt;
  logic             r_arith;
  logic             r_sign;
  logic             r_sticky;

  logic [WIDTH-1:0] w_stage_data;
  logic             w_stage_lost;
  logic             w_accept;

  sr_stage #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W),
    .K_W   (CNT_W)
  ) u_stage (
    .data         (r_data),
    .k            (r_cnt),
    .en           (r_amt[r_cnt]),
    .arith        (r_arith),
    .sign         (r_sign),
    .shifted      (w_stage_data),
    .lost_bits_or (w_stage_lost)
  );

  assign in_ready   = (r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready);
  assign w_accept   = in_valid & in_ready;
  assign out_valid  = (r_state == ST_DONE);
  assign out_data   = r_data;
  assign out_sticky = r_sticky;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (in_valid) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (r_cnt == C_LAST) w_state_nxt = ST_DONE;
      ST_DONE:  if (out_ready) w_state_nxt = in_valid ? ST_SHIFT : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_data   <= '0;
      r_amt    <= '0;
      r_arith  <= 1'b0;
      r_sign   <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_data   <= in_data;
        r_amt    <= in_amt;
        r_arith  <= in_arith;
        r_sign   <= in_data[WIDTH-1];
        r_sticky <= 1'b0;
        r_cnt    <= '0;
      end else if (r_state == ST_SHIFT) begin
        r_data   <= w_stage_data;
        r_sticky <= r_sticky | w_stage_lost;
        r_cnt    <= (r_cnt == C_LAST) ? '0 : r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_align_shift_right.sv
// ============================================================================
// Module : tb_align_shift_right
// Brief  : Randomized and directed self-checking bench for align_shift_right.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_align_shift_right;

  localparam int W  = 64;
  localparam int AW = 6;
  localparam int LAT = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [AW-1:0] in_amt = '0;
  logic          in_arith = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_sticky;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ready_mode = 1;  // 0 random, 1 high, 2 low, 3 driven by the stimulus block

  typedef struct {
    logic [W-1:0] data;
    logic         sticky;
    int           acc_edge;
    logic         has_lit;
    logic [W-1:0] lit_data;
    logic         lit_sticky;
  } exp_t;

  exp_t q[$];

  logic         lit_pending = 1'b0;
  logic [W-1:0] lit_data_nxt;
  logic         lit_sticky_nxt;

  align_shift_right #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_amt     (in_amt),
    .in_arith   (in_arith),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sticky (out_sticky)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain shift operators on the whole word.
  function automatic logic [W-1:0] model_data(input logic [W-1:0] d, input int amt, input logic ar);
    if (ar) return W'($signed(d) >>> amt);
    return d >> amt;
  endfunction

  function automatic logic model_sticky(input logic [W-1:0] d, input int amt);
    logic [W-1:0] m;
    m = (amt == 0) ? '0 : ({W{1'b1}} >> (W - amt));
    return |(d & m);
  endfunction

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = ($urandom_range(0, 3) != 0);
      1: out_ready = 1'b1;
      2: out_ready = 1'b0;
      default: ;
    endcase
  end

  // Compare process: every negedge, outputs against the queue-based model.
  always @(negedge clk) begin
    logic exp_valid, exp_ready;
    exp_t e;
    if (!rst_n) begin
      q.delete();
    end else begin
      exp_valid = (q.size() > 0) && ((cyc - q[0].acc_edge) >= LAT);
      exp_ready = exp_valid ? out_ready : (q.size() == 0);
      chk("out_valid", W'(out_valid), W'(exp_valid));
      chk("in_ready", W'(in_ready), W'(exp_ready));
      if (exp_valid && out_valid) begin
        chk("out_data", out_data, q[0].data);
        chk("out_sticky", W'(out_sticky), W'(q[0].sticky));
        if (q[0].has_lit) begin
          chk("lit_data", out_data, q[0].lit_data);
          chk("lit_sticky", W'(out_sticky), W'(q[0].lit_sticky));
        end
      end
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && in_ready) begin
        e.data       = model_data(in_data, int'(in_amt), in_arith);
        e.sticky     = model_sticky(in_data, int'(in_amt));
        e.acc_edge   = cyc + 1;
        e.has_lit    = lit_pending;
        e.lit_data   = lit_data_nxt;
        e.lit_sticky = lit_sticky_nxt;
        q.push_back(e);
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input logic [AW-1:0] a, input logic ar);
    bit done;
    done = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_arith = ar;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    if (!done) chk("send_timeout", 64'd0, 64'd1);
    in_valid    = 1'b0;
    lit_pending = 1'b0;
  endtask

  task automatic send_lit(input logic [W-1:0] d, input logic [AW-1:0] a, input logic ar,
                          input logic [W-1:0] ld, input logic ls);
    lit_pending    = 1'b1;
    lit_data_nxt   = ld;
    lit_sticky_nxt = ls;
    send(d, a, ar);
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (q.size() == 0) done = 1;
    end
    if (!done) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    logic [W-1:0] held_d;
    logic         held_s;
    bit           seen;

    // Pin the model with hand-computed values.
    chk("model_lsr", model_data(64'h8000_0000_0000_0000, 4, 1'b0), 64'h0800_0000_0000_0000);
    chk("model_asr", model_data(64'h8000_0000_0000_0000, 4, 1'b1), 64'hF800_0000_0000_0000);
    chk("model_stk", W'(model_sticky(64'hFF, 4)), 64'd1);
    chk("model_stk0", W'(model_sticky(64'hFF, 0)), 64'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", W'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_sticky", W'(out_sticky), 64'd0);
    chk("rst_in_ready", W'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send_lit(64'h8000_0000_0000_0000, 6'd4, 1'b0, 64'h0800_0000_0000_0000, 1'b0);
    drain();
    send_lit(64'h8000_0000_0000_0000, 6'd4, 1'b1, 64'hF800_0000_0000_0000, 1'b0);
    drain();
    send_lit(64'hFF, 6'd4, 1'b0, 64'h0F, 1'b1);
    drain();
    send_lit(64'hFF, 6'd0, 1'b0, 64'hFF, 1'b0);
    drain();
    send_lit(64'h8000_0000_0000_0000, 6'd63, 1'b0, 64'h1, 1'b0);
    drain();
    send_lit(64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    drain();

    // Backpressure, then simultaneous consume + accept.
    ready_mode = 2;
    @(posedge clk);
    #1;
    send_lit(64'h8000_0000_0000_0123, 6'd8, 1'b1, 64'hFF80_0000_0000_0001, 1'b1);
    ready_mode = 3;
    out_ready  = 1'b0;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    if (!seen) chk("bp_valid_timeout", 64'd0, 64'd1);
    held_d = out_data;
    held_s = out_sticky;
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_data", out_data, held_d);
      chk("bp_hold_sticky", W'(out_sticky), W'(held_s));
      chk("bp_in_ready", W'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_lit(64'h10, 6'd1, 1'b0, 64'h8, 1'b0);
    ready_mode = 1;
    drain();

    // Randomized operands with random gaps and random backpressure.
    ready_mode = 0;
    for (int n = 0; n < 60; n++) begin
      logic [W-1:0] d;
      d = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: d = d & 64'h0000_0000_0000_FFFF;
        1: d[W-1] = 1'b1;
        default: ;
      endcase
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send(d, AW'($urandom), 1'(($urandom)));
    end
    ready_mode = 1;
    drain();

    // Asynchronous reset while in SHIFT with cnt == 3.
    send(64'hDEAD_BEEF_CAFE_F00D, 6'd63, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", W'(out_valid), 64'd0);
    chk("arst_in_ready", W'(in_ready), 64'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_lit(64'h100, 6'd8, 1'b0, 64'h1, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
